memory_line_responder: RTL and testbench
========================================

# memory_line_responder

Main-memory side of the cache refill interface: accepts a line-fill request carrying a 15-bit word address and returns the 4-word line containing it as a critical-word-first, wrap-around burst with valid/ready backpressure. It sits below the direct-mapped cache (1K lines, 4 words/line, 3-bit tag) and owns the synthesizable main-memory array. A side-band init port preloads memory contents for simulation and bring-up.

## Interface

- ADDR_W, 15, word-address width (3 tag + 10 index + 2 offset)
- DATA_W, 32, word width
- LINE_WORDS, 4, words per line (fixed; offset width 2)
- ACCESS_LATENCY, 4, wait cycles between request acceptance and first beat; legal range 4..15
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  line-fill request present
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_W  word address of the critical word
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  cache accepts the beat
- rsp_data  out  DATA_W  word data
- rsp_word  out  2  offset of the word within the line
- rsp_last  out  1  final beat of the burst
- init_we  in  1  memory preload write strobe
- init_addr  in  ADDR_W  preload word address
- init_data  in  DATA_W  preload data

## Operation

- States: IDLE, WAIT, BURST.
- IDLE: req_ready=1. On req_valid: latch line base = req_addr with bits[1:0] cleared, start offset = req_addr[1:0], clear the wait counter, and go to WAIT.
- WAIT: req_ready=0. The counter counts ACCESS_LATENCY cycles.
  - During the first LINE_WORDS of those cycles, the line buffer is loaded one word per cycle from base+0 .. base+3.
  - When the count completes, go to BURST with beat=0.
- BURST: rsp_valid=1.
  - rsp_word = (start offset + beat) mod 4. rsp_data = buffer[rsp_word]. rsp_last = (beat==3).
  - A beat advances only on rsp_valid && rsp_ready.
  - The handshake on beat 3 returns the block to IDLE.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data, rsp_word and rsp_last are held stable and no beat is skipped.
- Init port:
  - Honored only in IDLE; writes mem[init_addr] = init_data.
  - init_we in WAIT or BURST is ignored. No write occurs and the line buffer is unaffected.
  - init_we and request acceptance in the same IDLE cycle: the write lands first, so the fetched line sees the new data.
- Memory contents are not cleared by reset. Addresses are word-granular and the array holds 2^ADDR_W words.

## Timing

- Request accepted in cycle T: WAIT covers T+1..T+ACCESS_LATENCY. The first rsp_valid is in T+ACCESS_LATENCY+1.
- With rsp_ready held high, beats occur in T+L+1 .. T+L+4 (L = ACCESS_LATENCY), and rsp_last is high in T+L+4.
- req_ready is high again in T+L+5.
- req_ready is combinational from state (state==IDLE). There is no request pipelining; at most one request is outstanding.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_last=0, rsp_word=0, rsp_data=0, counters 0.
- Reset mid-WAIT or mid-BURST aborts the burst. rsp_valid is 0 in the cycle after rst, no rsp_last is issued, and the next request is served normally.

## Structure

- cache_pkg holds:
  - ADDR_W, DATA_W, OFFSET_W=2, INDEX_W=10, TAG_W=3, LINE_WORDS=4
  - the state enum {IDLE, WAIT, BURST}
  - a line-base helper (clear the offset bits)
- Sub-module mem_array: one write port (init), one synchronous read port (line-buffer fill), DATA_W x 2^ADDR_W.
- The FSM, wait counter, 2-bit beat counter and 4-word line buffer live in memory_line_responder.

## Test plan

- Critical-word-first wrap:
  - Stimulus: preload mem[0x400..0x403]=0xA0..0xA3; request 0x0402 in cycle T, L=4, rsp_ready=1.
  - Required: beats in T+5..T+8 = (A2,w2), (A3,w3), (A0,w0), (A1,w1,last); req_ready=1 in T+9.
- Aligned request:
  - Stimulus: request 0x1FFC; mem 0x1FFC..0x1FFF = 1,2,3,4.
  - Required: beats ordered w0..w3 with data 1,2,3,4; the read does not spill into 0x2000.
- Backpressure:
  - Stimulus: drop rsp_ready for 3 cycles while beat 1 is presented.
  - Required: rsp_data, rsp_word and rsp_last are unchanged for those 3 cycles; all 4 words are delivered exactly once.
- Back-to-back requests:
  - Stimulus: hold req_valid with address 0x0800 through a burst.
  - Required: req_ready stays low until the cycle after the rsp_last handshake; the second request is accepted there and its first beat follows L+1 cycles later.
- Init interaction:
  - Stimulus: init_we to 0x0401 with data 0x55 in the same IDLE cycle as request 0x0400.
  - Required: beat w1 returns 0x55.
  - Stimulus: init_we to 0x0402 with data 0x66 during WAIT.
  - Required: the write is ignored; w2 returns the old value, and a later read also returns the old value.
- Reset mid-burst:
  - Stimulus: assert rst for one cycle at beat 2.
  - Required: next cycle has rsp_valid=0, rsp_last never seen, req_ready=1; a fresh request to 0x0402 completes correctly.

Source files
------------

// File: rtl/memory_line_responder_pkg.sv
// Shared constants and helpers for the cache refill path.
// Line geometry, responder state encodings and line-base arithmetic.
package memory_line_responder_pkg;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 32;
    localparam int OFFSET_W   = 2;
    localparam int INDEX_W    = 10;
    localparam int TAG_W      = 3;
    localparam int LINE_WORDS = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    function automatic logic [ADDR_W-1:0] line_base(
        input logic [ADDR_W-1:0] addr
    );
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/memory_line_responder_mem_array.sv
// Main-memory word array: one write port, one registered read port.
// A same-cycle write to the read address is forwarded to the read data.
module memory_line_responder_mem_array #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/memory_line_responder.sv
// Line-fill responder: fetches a 4-word line after a fixed access latency
// and returns it critical-word-first with valid/ready backpressure.
module memory_line_responder #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 32,
    parameter int LINE_WORDS     = 4,
    parameter int ACCESS_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_word,
    output logic              rsp_last,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data
);

    import memory_line_responder_pkg::*;

    localparam logic [3:0] LW       = 4'(LINE_WORDS);
    localparam logic [3:0] LAT_LAST = 4'(ACCESS_LATENCY - 1);
    localparam logic [1:0] BEAT_END = 2'(LINE_WORDS - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-3:0] base_hi;
    logic [1:0]        start;
    logic [1:0]        beat;
    logic [DATA_W-1:0] line_buf [4];

    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] req_base;
    logic [1:0]        next_off;
    logic [1:0]        cur_word;
    logic              in_burst;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_ready && req_valid;
    assign wr_en     = init_we && (state == S_IDLE);
    assign req_base  = line_base(req_addr);
    assign next_off  = cnt[1:0] + 2'd1;
    assign in_burst  = (state == S_BURST);
    assign cur_word  = start + beat;

    // Reads are issued one cycle ahead: word 0 on acceptance, word k+1
    // in WAIT cycle k, so word k is in rd_data during WAIT cycle k.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = req_base;
        if (accept) begin
            rd_en = 1'b1;
        end else if ((state == S_WAIT) && (cnt < LW - 4'd1)) begin
            rd_en   = 1'b1;
            rd_addr = {base_hi, next_off};
        end
    end

    memory_line_responder_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) mem_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (init_addr),
        .wr_data (init_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        rsp_valid = in_burst;
        rsp_word  = 2'd0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        if (in_burst) begin
            rsp_word = cur_word;
            rsp_data = line_buf[cur_word];
            rsp_last = (beat == BEAT_END);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            base_hi <= '0;
            start   <= '0;
            beat    <= '0;
            for (int i = 0; i < 4; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        base_hi <= req_base[ADDR_W-1:2];
                        start   <= req_addr[1:0];
                        cnt     <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt < LW) begin
                        line_buf[cnt[1:0]] <= rd_data;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == LAT_LAST) begin
                        cnt   <= '0;
                        beat  <= '0;
                        state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (rsp_ready) begin
                        beat <= beat + 2'd1;
                        if (beat == BEAT_END) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_line_responder.sv
// Directed bench for memory_line_responder: table of wrap bursts plus
// backpressure, back-to-back, init-port and reset-abort sequences.
module tb_memory_line_responder;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [14:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_word;
    logic        rsp_last;
    logic        init_we;
    logic [14:0] init_addr;
    logic [31:0] init_data;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        logic [14:0]       addr;
        logic [0:3][31:0]  data;
        logic [0:3][1:0]   word;
    } vec_t;

    vec_t vecs [4];

    memory_line_responder #(
        .ADDR_W         (15),
        .DATA_W         (32),
        .LINE_WORDS     (4),
        .ACCESS_LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_word  (rsp_word),
        .rsp_last  (rsp_last),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [31:0] d);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        step();
        init_we = 1'b0;
    endtask

    // Issue one request with rsp_ready high and check every beat and timing.
    task automatic run_req(input string nm, input logic [14:0] a,
                           input logic [0:3][31:0] ed,
                           input logic [0:3][1:0] ew);
        int t;
        int got;
        int guard;
        req_addr  = a;
        req_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
        t = cyc;
        step();
        req_valid = 1'b0;
        got   = 0;
        guard = 0;
        while (got < 4 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (rsp_valid) begin
                if (got == 0) begin
                    chk({nm, "_first_lat"}, 64'(cyc - t), 64'(L + 1));
                end
                chk({nm, "_beat"}, {29'd0, rsp_data, rsp_word, rsp_last},
                    {29'd0, ed[got], ew[got], (got == 3)});
                got++;
            end
        end
        if (got < 4) begin
            chk({nm, "_timeout"}, 64'(got), 64'd4);
        end
        @(negedge clk);
        chk({nm, "_ready_again"}, {31'd0, req_ready, 32'(cyc - t)},
            {31'd0, 1'b1, 32'(L + 5)});
        step();
    endtask

    task automatic wait_valid(input string nm);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!rsp_valid) begin
            chk({nm, "_timeout"}, 64'(rsp_valid), 64'd1);
        end
    endtask

    initial begin
        int t;
        int t2;
        int tl;
        int guard;
        logic seen_last;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;

        vecs[0] = '{15'h0402, {32'hA2, 32'hA3, 32'hA0, 32'hA1},
                    {2'd2, 2'd3, 2'd0, 2'd1}};
        vecs[1] = '{15'h1FFC, {32'd1, 32'd2, 32'd3, 32'd4},
                    {2'd0, 2'd1, 2'd2, 2'd3}};
        vecs[2] = '{15'h0801, {32'h81, 32'h82, 32'h83, 32'h80},
                    {2'd1, 2'd2, 2'd3, 2'd0}};
        vecs[3] = '{15'h7FFF, {32'hC3, 32'hC0, 32'hC1, 32'hC2},
                    {2'd3, 2'd0, 2'd1, 2'd2}};

        repeat (3) step();
        @(negedge clk);
        chk("rst_outputs",
            {26'd0, req_ready, rsp_valid, rsp_last, rsp_word, rsp_data},
            {26'd0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0});
        step();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            preload(15'h0400 + 15'(i), 32'hA0 + 32'(i));
            preload(15'h1FFC + 15'(i), 32'd1 + 32'(i));
            preload(15'h0800 + 15'(i), 32'h80 + 32'(i));
            preload(15'h7FFC + 15'(i), 32'hC0 + 32'(i));
        end
        preload(15'h2000, 32'hDEAD);

        for (int i = 0; i < 4; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].addr,
                    vecs[i].data, vecs[i].word);
        end

        // Backpressure on beat 1 for three cycles.
        req_addr  = 15'h0400;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        wait_valid("bp");
        chk("bp_beat0", {rsp_data, rsp_word, rsp_last},
            {32'hA0, 2'd0, 1'b0});
        step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k),
                {rsp_valid, rsp_data, rsp_word, rsp_last},
                {1'b1, 32'hA1, 2'd1, 1'b0});
        end
        step();
        rsp_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp_beat%0d", k),
                {rsp_valid, rsp_data, rsp_word, rsp_last},
                {1'b1, 32'hA0 + 32'(k), 2'(k), (k == 3)});
        end
        @(negedge clk);
        chk("bp_no_extra", 64'(rsp_valid), 64'd0);
        step();

        // Back-to-back: req_valid held through the whole first burst.
        req_addr  = 15'h0800;
        req_valid = 1'b1;
        @(negedge clk);
        t     = cyc;
        tl    = -100;
        guard = 0;
        step();
        @(negedge clk);
        while (!req_ready && guard < 40) begin
            if (rsp_valid && rsp_last) tl = cyc;
            @(negedge clk);
            guard++;
        end
        chk("b2b_gap", {32'(cyc - t), 32'(cyc - tl)},
            {32'(L + 5), 32'd1});
        t2 = cyc;
        step();
        req_valid = 1'b0;
        wait_valid("b2b");
        chk("b2b_second", {32'(cyc - t2), rsp_data},
            {32'(L + 1), 32'h80});
        repeat (3) @(negedge clk);
        chk("b2b_last", {rsp_valid, rsp_last, rsp_data},
            {1'b1, 1'b1, 32'h83});
        step();

        // Init write with acceptance, then an ignored write during WAIT.
        req_addr  = 15'h0400;
        req_valid = 1'b1;
        init_we   = 1'b1;
        init_addr = 15'h0401;
        init_data = 32'h55;
        step();
        req_valid = 1'b0;
        init_addr = 15'h0402;
        init_data = 32'h66;
        step();
        init_we = 1'b0;
        wait_valid("init");
        for (int k = 0; k < 4; k++) begin
            logic [0:3][31:0] ex;
            ex = {32'hA0, 32'h55, 32'hA2, 32'hA3};
            chk($sformatf("init_beat%0d", k), {rsp_data, rsp_word},
                {ex[k], 2'(k)});
            @(negedge clk);
        end
        step();
        run_req("reread", 15'h0402,
                {32'hA2, 32'hA3, 32'hA0, 32'h55},
                {2'd2, 2'd3, 2'd0, 2'd1});

        // Reset during beat 2 aborts the burst.
        req_addr  = 15'h0403;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        wait_valid("rstb");
        seen_last = rsp_last;
        step();
        @(negedge clk);
        seen_last |= rsp_last;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstb_beat2", {rsp_valid, rsp_word, rsp_data},
            {1'b1, 2'd1, 32'h55});
        seen_last |= rsp_last;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen_last |= rsp_last;
            if (k == 0) begin
                chk("rstb_after", {rsp_valid, rsp_last, req_ready},
                    {1'b0, 1'b0, 1'b1});
            end
        end
        chk("rstb_no_last", 64'(seen_last), 64'd0);
        step();
        run_req("post_rst", 15'h0402,
                {32'hA2, 32'hA3, 32'hA0, 32'h55},
                {2'd2, 2'd3, 2'd0, 2'd1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
